// File: rtl/tx_share_arbiter_if.sv
// Requester and transmit-engine signal bundle for tx_share_arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface tx_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                eng_start;
    logic [DW-1:0]       eng_data;
    logic                eng_done;
    logic [IW-1:0]       grant_id;
    logic                busy;
    logic                err_timeout;

    modport slave (
        input  req_valid, req_data, eng_done,
        output req_ready, eng_start, eng_data, grant_id, busy, err_timeout
    );

    modport master (
        output req_valid, req_data, eng_done,
        input  req_ready, eng_start, eng_data, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/tx_share_arbiter.sv
// Round-robin sharing of one start/done transmit engine among N_REQ requesters,
// with a bounded wait for done and a timeout error that still releases the requester.
module tx_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 3
) (
    input  logic              clk,
    input  logic              rst,
    tx_share_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]       state_reg;
    logic [IW-1:0]    rr_ptr_reg;
    logic [IW-1:0]    grant_id_reg;
    logic [DW-1:0]    eng_data_reg;
    logic [TW-1:0]    timer_reg;
    logic [N_REQ-1:0] req_ready_reg;
    logic             eng_start_reg;
    logic             busy_reg;
    logic             err_timeout_reg;

    logic [DW-1:0]    data_arr [N_REQ];
    logic [IW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic [IW-1:0]    winner;
    logic             any_valid;
    logic             timer_done;
    logic [IW-1:0]    next_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [IW:0] sum;
            assign data_arr[gi] = bus.req_data[gi*DW +: DW];
            // Candidate gi is the requester gi positions after the round-robin pointer.
            assign sum          = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                          : sum[IW-1:0];
            assign cand_hit[gi] = bus.req_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

    assign any_valid  = |bus.req_valid;
    assign timer_done = (timer_reg == TW'(TIMEOUT));
    assign next_ptr   = (grant_id_reg == IW'(N_REQ - 1)) ? '0 : grant_id_reg + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            eng_data_reg    <= '0;
            timer_reg       <= '0;
            req_ready_reg   <= '0;
            eng_start_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            eng_start_reg   <= 1'b0;
            req_ready_reg   <= '0;
            err_timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id_reg  <= winner;
                        eng_data_reg  <= data_arr[winner];
                        eng_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_START;
                    end
                end
                S_START: begin
                    timer_reg <= TW'(1);
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // Done on the last permitted cycle still counts as success.
                    if (bus.eng_done || timer_done) begin
                        req_ready_reg   <= N_REQ'(1) << grant_id_reg;
                        err_timeout_reg <= !bus.eng_done;
                        state_reg       <= S_ACK;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_ACK: begin
                    rr_ptr_reg <= next_ptr;
                    busy_reg   <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.eng_start   = eng_start_reg;
    assign bus.eng_data    = eng_data_reg;
    assign bus.grant_id    = grant_id_reg;
    assign bus.busy        = busy_reg;
    assign bus.err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_tx_share_arbiter.sv
// Scoreboard bench for tx_share_arbiter: a transaction-level model predicts each grant,
// and an independent monitor checks engine starts and completion pulses against it.
module tb_tx_share_arbiter;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 3;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } start_t;

    typedef struct {
        int id;
        bit err;
        int lat;
    } ack_t;

    logic clk;
    logic rst;
    logic eng_hit;
    logic spur_done;

    int vectors;
    int errors;
    int cyc;

    start_t sq[$];
    ack_t   aq[$];
    int     kq[$];

    logic [N-1:0]  pending;
    logic [DW-1:0] dat [N];
    int            ptr;

    tx_share_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    tx_share_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.eng_done = eng_hit | spur_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Engine model: answers k cycles after the start strobe; k == 0 means it never answers.
    initial begin
        int cnt;
        cnt     = 0;
        eng_hit = 1'b0;
        forever begin
            @(negedge clk);
            eng_hit = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) eng_hit = 1'b1;
                end
                if (bus.eng_start) cnt = (kq.size() > 0) ? kq.pop_front() : 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a start or a completion.
    initial begin
        bit     prev_start;
        bit     idle_chk;
        int     start_cyc;
        int     last_id;
        logic [DW-1:0] last_data;
        start_t s;
        ack_t   a;
        prev_start = 0;
        idle_chk   = 0;
        start_cyc  = 0;
        last_id    = 0;
        last_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 0;
                idle_chk   = 0;
            end else begin
                if (idle_chk) begin
                    chk("idle_busy", 32'(bus.busy), 0);
                    chk("idle_grant_hold", 32'(bus.grant_id), 32'(last_id));
                    chk("idle_data_hold", 32'(bus.eng_data), 32'(last_data));
                    idle_chk = 0;
                end
                if (bus.eng_start) begin
                    if (prev_start) flag("eng_start_back_to_back");
                    if (sq.size() == 0) begin
                        flag("unexpected_eng_start");
                    end else begin
                        s = sq.pop_front();
                        chk("grant_id", 32'(bus.grant_id), 32'(s.id));
                        chk("eng_data", 32'(bus.eng_data), 32'(s.data));
                        chk("busy_at_start", 32'(bus.busy), 1);
                        start_cyc = cyc;
                        last_id   = s.id;
                        last_data = s.data;
                    end
                end
                prev_start = bus.eng_start;
                if (bus.req_ready != '0 || bus.err_timeout) begin
                    if (aq.size() == 0) begin
                        flag("unexpected_ready_or_err");
                    end else begin
                        a = aq.pop_front();
                        chk("req_ready", 32'(bus.req_ready), 32'(1) << a.id);
                        chk("err_timeout", 32'(bus.err_timeout), 32'(a.err));
                        chk("ready_latency", 32'(cyc - start_cyc), 32'(a.lat));
                        idle_chk = 1;
                    end
                end
            end
        end
    end

    task automatic drive();
        logic [N*DW-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = dat[i];
        bus.req_valid = pending;
        bus.req_data  = d;
    endtask

    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = (ptr + off) % N;
            if (pending[idx]) return idx;
        end
        return -1;
    endfunction

    // Predict the next grant from the pending set and push expectations.
    task automatic predict_push(input int k, output int w);
        bit err;
        w = pick();
        if (w < 0) return;
        err = (k == 0) || (k > TIMEOUT);
        sq.push_back('{w, dat[w]});
        aq.push_back('{w, err, err ? TIMEOUT + 1 : k + 1});
        kq.push_back(k);
        ptr = (w + 1) % N;
    endtask

    task automatic run_txn(input int k, output int w);
        bit got;
        predict_push(k, w);
        if (w < 0) return;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) got = 1;
        end
        if (!got) begin
            flag("ready_wait_expired");
            sq.delete();
            aq.delete();
            kq.delete();
        end
        pending[w] = 1'b0;
        drive();
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d);
        pending[i] = 1'b1;
        dat[i]     = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_eng_start"}, 32'(bus.eng_start), 0);
        chk({tag, "_eng_data"}, 32'(bus.eng_data), 0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 0);
    endtask

    initial begin
        int w;
        int kk;
        bit got;
        vectors   = 0;
        errors    = 0;
        spur_done = 1'b0;
        pending   = '0;
        ptr       = 0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        drive();

        rst = 1'b1;
        #3 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Spurious done while idle with no requests.
        spur_done = 1'b1;
        repeat (2) @(negedge clk);
        spur_done = 1'b0;
        chk("spur_idle_busy", 32'(bus.busy), 0);
        chk("spur_idle_ready", 32'(bus.req_ready), 0);

        // Single request from requester 1, done two cycles after start.
        set_req(1, 8'hA5);
        drive();
        run_txn(2, w);
        $display("txn single: grant %0d", w);

        // Done latency sweep, then an engine that never answers.
        for (int k = 0; k <= TIMEOUT; k++) begin
            kk = (k == TIMEOUT) ? 0 : k + 1;
            set_req($urandom_range(0, N - 1), 8'($urandom_range(0, 255)));
            drive();
            run_txn(kk, w);
            $display("txn sweep k=%0d: grant %0d", kk, w);
        end

        // All requesters continuously active, done latency 1.
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom_range(0, 255)));
        drive();
        for (int t = 0; t < N + 1; t++) begin
            run_txn(1, w);
            $display("txn continuous: grant %0d", w);
            set_req(w, 8'($urandom_range(0, 255)));
            drive();
        end
        while (pending != '0) begin
            run_txn(1, w);
            $display("txn drain: grant %0d", w);
        end

        // Late done lands in the next START and must be ignored.
        set_req(0, 8'h3C);
        set_req(2, 8'hC3);
        drive();
        run_txn(6, w);
        $display("txn late-done: grant %0d", w);
        run_txn(2, w);
        $display("txn after late-done: grant %0d", w);

        // Pointer wrap: last grant 3, then requesters 0 and 3 both valid.
        set_req(3, 8'h11);
        drive();
        run_txn(1, w);
        $display("txn wrap setup: grant %0d", w);
        set_req(0, 8'h22);
        set_req(3, 8'h33);
        drive();
        run_txn(1, w);
        $display("txn wrap: grant %0d", w);
        run_txn(1, w);
        $display("txn wrap next: grant %0d", w);

        // Randomized traffic with idle gaps and spurious idle dones.
        for (int t = 0; t < 150; t++) begin
            if (pending == '0) begin
                repeat ($urandom_range(0, 3)) begin
                    spur_done = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                spur_done = 1'b0;
                set_req($urandom_range(0, N - 1), 8'($urandom_range(0, 255)));
                drive();
            end
            run_txn($urandom_range(0, 6), w);
            $display("txn random %0d: grant %0d", t, w);
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom_range(0, 255)));
            end
            drive();
        end
        while (pending != '0) begin
            run_txn(1, w);
            $display("txn random drain: grant %0d", w);
        end

        // Asynchronous reset in the middle of WAIT.
        set_req(1, 8'h5A);
        drive();
        predict_push(3, w);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.eng_start) got = 1;
        end
        if (!got) flag("reset_test_start_wait_expired");
        @(posedge clk);
        #1 rst = 1'b0;
        sq.delete();
        aq.delete();
        kq.delete();
        #1 check_all_zero("async_reset");
        pending = '0;
        ptr     = 0;
        set_req(2, 8'h77);
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_txn(2, w);
        $display("txn after reset: grant %0d", w);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sq.size() + aq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
